// File: rtl/page_checker_pkg.sv
// Shared definitions for the DDR page pattern generator/checker.
package page_checker_pkg;

    // Instruction opcodes (inst[11:8]); 7..F decode as NOP
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_SEED  = 4'h1;
    localparam logic [3:0] OP_MODE  = 4'h2;
    localparam logic [3:0] OP_NEXT  = 4'h3;
    localparam logic [3:0] OP_CHECK = 4'h4;
    localparam logic [3:0] OP_CLEAR = 4'h5;
    localparam logic [3:0] OP_STAT  = 4'h6;

    // Pattern generation modes
    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_INCR  = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_WALK  = 2'd3
    } mode_e;

    // Compare sequencer states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CMP  = 1'b1
    } state_e;

    localparam logic [31:0] LFSR_TAPS   = 32'h80200003;
    localparam logic [31:0] PATTERN_RST = 32'h00000001;

    // Replicate a byte across a 32-bit word
    function automatic logic [31:0] rep4(input logic [7:0] b);
        return {4{b}};
    endfunction

endpackage

// File: rtl/page_pattern_gen.sv
// Mode register, pattern register and the SEED/NEXT update rules.
module page_pattern_gen
    import page_checker_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        seed_i,
    input  logic        mode_i,
    input  logic        next_i,
    input  logic [7:0]  imm_i,
    output logic [31:0] pattern_o,
    output mode_e       mode_o
);

    mode_e       mode_q, mode_d;
    logic [31:0] pattern_q, pattern_d;

    // Next mode/pattern: SEED loads from the immediate, NEXT advances by mode
    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern_q;
        if (mode_i) begin
            mode_d = mode_e'(imm_i[1:0]);
        end
        if (seed_i) begin
            case (mode_q)
                MODE_CONST: pattern_d = rep4(imm_i);
                MODE_INCR:  pattern_d = {24'h0, imm_i};
                MODE_LFSR:  pattern_d = (imm_i == 8'h00) ? 32'h00000001 : rep4(imm_i);
                MODE_WALK:  pattern_d = 32'h1 << imm_i[4:0];
                default:    pattern_d = pattern_q;
            endcase
        end else if (next_i) begin
            case (mode_q)
                MODE_CONST: pattern_d = pattern_q;
                MODE_INCR:  pattern_d = pattern_q + 32'h1;
                // Galois form: shift right, fold taps in when bit 0 falls out
                MODE_LFSR:  pattern_d = {1'b0, pattern_q[31:1]} ^ (pattern_q[0] ? LFSR_TAPS : 32'h0);
                MODE_WALK:  pattern_d = {pattern_q[30:0], pattern_q[31]};
                default:    pattern_d = pattern_q;
            endcase
        end
    end

    // Generator state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q    <= MODE_CONST;
            pattern_q <= PATTERN_RST;
        end else begin
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
        end
    end

    assign pattern_o = pattern_q;
    assign mode_o    = mode_q;

endmodule

// File: rtl/page_checker.sv
// DDR page checker: instruction decode, byte-serial compare, error count, status mux.
module page_checker
    import page_checker_pkg::*;
#(
    parameter int ECNT_W = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] inst,
    input  logic        inst_en,
    input  logic [31:0] page,
    output logic        ready,
    output logic [31:0] pattern,
    output logic        error,
    output logic [7:0]  status
);

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [31:0]         page_q, page_d;
    logic [3:0]          mask_q, mask_d;
    logic                error_q, error_d;
    logic [ECNT_W-1:0]   ecnt_q, ecnt_d;
    logic [1:0]          ssel_q, ssel_d;

    logic [3:0]          opcode;
    logic [7:0]          imm;
    logic                accept;
    logic                byte_mis;
    logic [3:0]          mask_fin;
    logic [7:0]          ecnt8;
    mode_e               mode;
    logic [1:0]          mode_bits;

    assign opcode    = inst[11:8];
    assign imm       = inst[7:0];
    // Strobes while busy are dropped, never queued
    assign accept    = inst_en && (state_q == ST_IDLE);
    assign ready     = (state_q == ST_IDLE);
    assign error     = error_q;
    assign mode_bits = mode;

    page_pattern_gen u_gen (
        .clock     (clock),
        .reset     (reset),
        .seed_i    (accept && (opcode == OP_SEED)),
        .mode_i    (accept && (opcode == OP_MODE)),
        .next_i    (accept && (opcode == OP_NEXT)),
        .imm_i     (imm),
        .pattern_o (pattern),
        .mode_o    (mode)
    );

    // Byte under comparison this cycle, and the mask including it
    always_comb begin
        byte_mis         = page_q[{idx_q, 3'b000} +: 8] != pattern[{idx_q, 3'b000} +: 8];
        mask_fin         = mask_q;
        mask_fin[idx_q]  = mask_q[idx_q] | byte_mis;
    end

    // Sequencer next state: decode in IDLE, walk bytes 0..3 in CMP
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        mask_d  = mask_q;
        error_d = error_q;
        ecnt_d  = ecnt_q;
        ssel_d  = ssel_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_CHECK: begin
                            page_d  = page;
                            mask_d  = 4'h0;
                            idx_d   = 2'd0;
                            state_d = ST_CMP;
                        end
                        OP_CLEAR: begin
                            ecnt_d  = '0;
                            error_d = 1'b0;
                            mask_d  = 4'h0;
                        end
                        OP_STAT: ssel_d = imm[1:0];
                        default: ;
                    endcase
                end
            end
            ST_CMP: begin
                mask_d = mask_fin;
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = ST_IDLE;
                    if (mask_fin != 4'h0) begin
                        error_d = 1'b1;
                        if (!(&ecnt_q)) begin
                            ecnt_d = ecnt_q + {{(ECNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer and status registers; reset aborts any compare in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            page_q  <= 32'h0;
            mask_q  <= 4'h0;
            error_q <= 1'b0;
            ecnt_q  <= '0;
            ssel_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            mask_q  <= mask_d;
            error_q <= error_d;
            ecnt_q  <= ecnt_d;
            ssel_q  <= ssel_d;
        end
    end

    // Low byte of the counter, zero-extended for narrow counters
    if (ECNT_W >= 8) begin : g_ecnt_wide
        assign ecnt8 = ecnt_q[7:0];
    end else begin : g_ecnt_narrow
        assign ecnt8 = {{(8-ECNT_W){1'b0}}, ecnt_q};
    end

    // Status follows the live sources through the registered selector
    always_comb begin
        case (ssel_q)
            2'd0:    status = ecnt8;
            2'd1:    status = {4'h0, mask_q};
            2'd2:    status = {5'h0, mode_bits, error_q};
            default: status = pattern[7:0];
        endcase
    end

endmodule

// File: tb/tb_page_checker.sv
// Randomized and directed bench for page_checker against a behavioural model.
module tb_page_checker;

    localparam int ECNT_W = 8;
    localparam int ECNT_MAX = (1 << ECNT_W) - 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] inst = 12'h0;
    logic        inst_en = 1'b0;
    logic [31:0] page = 32'h0;
    logic        ready;
    logic [31:0] pattern;
    logic        error;
    logic [7:0]  status;

    page_checker #(.ECNT_W(ECNT_W)) dut (
        .clock   (clock),
        .reset   (reset),
        .inst    (inst),
        .inst_en (inst_en),
        .page    (page),
        .ready   (ready),
        .pattern (pattern),
        .error   (error),
        .status  (status)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // Behavioural model state
    logic [31:0] m_pat;
    logic [1:0]  m_mode;
    logic [1:0]  m_ssel;
    logic        m_err;
    int          m_ecnt;
    logic [3:0]  m_full;
    logic [3:0]  m_mask;
    int          m_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pat  = 32'h1;
        m_mode = 2'd0;
        m_ssel = 2'd0;
        m_err  = 1'b0;
        m_ecnt = 0;
        m_full = 4'h0;
        m_mask = 4'h0;
        m_busy = 0;
    endtask

    // One clock edge of the model: a pending compare reveals one more mask bit,
    // otherwise an accepted instruction takes effect.
    task automatic model_edge();
        logic [7:0] im;
        im = inst[7:0];
        if (m_busy > 0) begin
            m_busy--;
            m_mask = m_full & 4'((1 << (4 - m_busy)) - 1);
            if (m_busy == 0 && m_full != 4'h0) begin
                m_err = 1'b1;
                if (m_ecnt < ECNT_MAX) m_ecnt++;
            end
        end else if (inst_en) begin
            case (inst[11:8])
                4'h1: case (m_mode)
                    2'd0: m_pat = {im, im, im, im};
                    2'd1: m_pat = {24'h0, im};
                    2'd2: m_pat = (im == 8'h0) ? 32'h1 : {im, im, im, im};
                    default: m_pat = 32'h1 << im[4:0];
                endcase
                4'h2: m_mode = im[1:0];
                4'h3: case (m_mode)
                    2'd0: ;
                    2'd1: m_pat = m_pat + 32'h1;
                    2'd2: m_pat = m_pat[0] ? ((m_pat >> 1) ^ 32'h80200003) : (m_pat >> 1);
                    default: m_pat = {m_pat[30:0], m_pat[31]};
                endcase
                4'h4: begin
                    m_full = 4'h0;
                    for (int b = 0; b < 4; b++)
                        if (page[b*8 +: 8] != m_pat[b*8 +: 8]) m_full[b] = 1'b1;
                    m_mask = 4'h0;
                    m_busy = 4;
                end
                4'h5: begin
                    m_ecnt = 0;
                    m_err  = 1'b0;
                    m_mask = 4'h0;
                end
                4'h6: m_ssel = im[1:0];
                default: ;
            endcase
        end
    endtask

    function automatic logic [7:0] m_status();
        case (m_ssel)
            2'd0: return 8'(m_ecnt);
            2'd1: return {4'h0, m_mask};
            2'd2: return {5'h0, m_mode, m_err};
            default: return m_pat[7:0];
        endcase
    endfunction

    // Model advances on every clock edge; async reset clears it at once
    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) model_reset();
            else model_edge();
        end
    end

    // Compare all outputs against the model on every falling edge
    always @(negedge clock) begin
        if (chk_on) begin
            chk("ready",   32'(ready),   32'(m_busy == 0));
            chk("pattern", pattern,      m_pat);
            chk("error",   32'(error),   32'(m_err));
            chk("status",  32'(status),  32'(m_status()));
        end
    end

    task automatic do_inst(input logic [3:0] op, input logic [7:0] im, input logic [31:0] pg);
        inst    = {op, im};
        page    = pg;
        inst_en = 1'b1;
        @(posedge clock);
        #1;
        inst_en = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!ready && k < 20) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk("ready_wait", 32'(ready), 32'h1);
    endtask

    initial begin
        int c;
        repeat (3) @(posedge clock);
        #2;
        reset  = 1'b1;
        chk_on = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_ready",   32'(ready),  32'h1);
        chk("rst_pattern", pattern,     32'h00000001);
        chk("rst_error",   32'(error),  32'h0);
        chk("rst_status",  32'(status), 32'h00);

        // Matching page: ready low for exactly four cycles, clean mask
        do_inst(4'h2, 8'h00, 32'h0);
        do_inst(4'h1, 8'hA5, 32'h0);
        do_inst(4'h4, 8'h00, 32'hA5A5A5A5);
        c = 0;
        while (!ready && c < 10) begin
            c++;
            @(posedge clock);
            #1;
        end
        chk("ready_low_cycles", 32'(c), 32'd4);
        do_inst(4'h6, 8'h01, 32'h0);
        chk("match_mask",  32'(status), 32'h00);
        chk("match_error", 32'(error),  32'h0);

        // Middle bytes differ
        do_inst(4'h4, 8'h00, 32'hA5005AA5);
        wait_ready();
        do_inst(4'h6, 8'h01, 32'h0);
        chk("mis_mask",  32'(status), 32'h06);
        chk("mis_error", 32'(error),  32'h1);
        do_inst(4'h6, 8'h00, 32'h0);
        chk("mis_ecnt",  32'(status), 32'h01);

        // LFSR and walking-one sequences
        do_inst(4'h2, 8'h02, 32'h0);
        do_inst(4'h1, 8'h00, 32'h0);
        chk("lfsr_seed0", pattern, 32'h00000001);
        do_inst(4'h3, 8'h00, 32'h0);
        chk("lfsr_next1", pattern, 32'h80200003);
        chk("model_lfsr1", m_pat,  32'h80200003);
        do_inst(4'h3, 8'h00, 32'h0);
        chk("lfsr_next2", pattern, 32'hC0300002);
        do_inst(4'h2, 8'h03, 32'h0);
        do_inst(4'h1, 8'h1F, 32'h0);
        chk("walk_seed", pattern, 32'h80000000);
        do_inst(4'h3, 8'h00, 32'h0);
        chk("walk_wrap", pattern, 32'h00000001);
        chk("model_walk", m_pat,  32'h00000001);

        // CLEAR strobed mid-compare is dropped; counter saturates
        do_inst(4'h2, 8'h00, 32'h0);
        do_inst(4'h1, 8'hA5, 32'h0);
        do_inst(4'h4, 8'h00, 32'h0);
        do_inst(4'h5, 8'h00, 32'h0);
        wait_ready();
        chk("clear_ignored", 32'(status), 32'h02);
        for (int i = 0; i < 256; i++) begin
            do_inst(4'h4, 8'h00, 32'h0);
            wait_ready();
        end
        chk("ecnt_sat",   32'(status), 32'hFF);
        chk("model_sat",  32'(m_ecnt), 32'd255);
        do_inst(4'h5, 8'h00, 32'h0);
        chk("clear_ecnt", 32'(status), 32'h00);
        chk("clear_err",  32'(error),  32'h0);

        // Reset during the second compare cycle of a failing CHECK
        do_inst(4'h4, 8'h00, 32'h0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_ready",  32'(ready),  32'h1);
        chk("abort_error",  32'(error),  32'h0);
        chk("abort_status", 32'(status), 32'h00);

        // Random instruction stream, including strobes while busy
        for (int i = 0; i < 3000; i++) begin
            logic [3:0]  op;
            logic [31:0] pg;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 6));
            pg = m_pat;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 2) == 0) pg[b*8 +: 8] = 8'($urandom);
            inst    = {op, 8'($urandom)};
            page    = pg;
            inst_en = ($urandom_range(0, 4) != 0);
            @(posedge clock);
            #1;
        end
        inst_en = 1'b0;
        repeat (6) @(posedge clock);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/page_checker.md
# page_checker

Sequencer-controlled DDR page pattern generator and checker. It sits on the sequencer's output-register instruction bus next to the DDR controller, LED bank and switch controller. It consumes the 32-bit page word produced by the DDR controller, generates the expected data pattern, and compares the two byte-by-byte. Status goes back to the sequencer through an input register. The same pattern word is also exported to feed write data.

## Interface
Parameters:
- `ECNT_W`, default 8: width of the saturating error counter.

Ports:
- `clock`, in, 1: the single clock; same domain as the DDR controller instruction side.
- `reset`, in, 1: asynchronous, active-low.
- `inst`, in, 12: instruction. `[11:8]` is the opcode, `[7:0]` is the immediate.
- `inst_en`, in, 1: instruction strobe. Taken only when `ready`=1.
- `page`, in, 32: data word from the DDR controller. Sampled only on CHECK accept.
- `ready`, out, 1: 1 when idle and able to accept an instruction.
- `pattern`, out, 32: current expected/generated pattern.
- `error`, out, 1: sticky mismatch flag.
- `status`, out, 8: status byte chosen by STAT, for a sequencer ireg.

## Operation
Opcodes (unlisted opcodes 7–F act as NOP):
- 0 NOP: no effect.
- 1 SEED: load `pattern` according to the current mode.
  - CONST: {imm,imm,imm,imm}.
  - INCR: {24'h0,imm}.
  - LFSR: {imm,imm,imm,imm}; if imm=0, load 32'h00000001 instead.
  - WALK: 32'h1 << imm[4:0].
- 2 MODE: mode ← imm[1:0] (0 CONST, 1 INCR, 2 LFSR, 3 WALK). `pattern` is not changed.
- 3 NEXT: advance the pattern.
  - CONST: unchanged.
  - INCR: +1 mod 2^32.
  - LFSR: Galois shift right. If bit0=1, XOR with taps 32'h80200003.
  - WALK: rotate left by 1.
- 4 CHECK: latch `page`. The block then compares one byte per cycle, byte 0 (`[7:0]`) first through byte 3. A mismatching byte i sets bit i of `mask` (4 bits, cleared at CHECK accept). At the end, if `mask`≠0: `error`←1 and `ecnt`←ecnt+1, saturating at all-ones.
- 5 CLEAR: `ecnt`←0, `error`←0, `mask`←0.
- 6 STAT: select the status source from imm[1:0].
  - 0: `ecnt` (low 8 bits, zero-extended if `ECNT_W`<8).
  - 1: {4'h0,mask}.
  - 2: {5'h0,mode,error}.
  - 3: `pattern[7:0]`.

FSM has two states:
- IDLE (`ready`=1). CHECK goes to CMP with byte index 0. All other opcodes execute in one cycle and stay in IDLE.
- CMP (`ready`=0). The byte index runs 0..3. At index 3 the block updates `error`/`ecnt` and returns to IDLE.

Rules:
- `inst_en` while `ready`=0 is ignored entirely. It is not queued and not an error.
- CHECK does not advance `pattern`. The sequencer issues NEXT explicitly.
- `status` is combinational from the registered selector and the registered sources. It tracks source changes without a new STAT.

Reset values:
- State IDLE, `ready`=1, `pattern`=32'h00000001, mode CONST.
- `ecnt`=0, `mask`=0, `error`=0.
- STAT selector 0, so `status`=8'h00.

Reset asserted during CMP aborts the compare immediately. No count update occurs.

## Timing
- An instruction accepted on edge N takes effect at edge N. New register values are visible after N.
- CHECK accepted at edge N:
  - `ready` is 0 during cycles N+1..N+4.
  - Byte i is compared at edge N+1+i.
  - `mask`, `error` and `ecnt` are final after edge N+4.
  - `ready`=1 from edge N+4, so the next instruction is accepted at N+5 at the earliest.
- Back-to-back single-cycle instructions are accepted every cycle.
- `page` must be stable only at the CHECK accept edge.

## Structure
- Shared package holds:
  - Opcode constants: OP_NOP, OP_SEED, OP_MODE, OP_NEXT, OP_CHECK, OP_CLEAR, OP_STAT.
  - Mode encodings.
  - FSM state encoding.
  - LFSR_TAPS=32'h80200003.
- Natural sub-module: `page_pattern_gen`, containing the mode register, the pattern register and the SEED/NEXT logic. The compare FSM, counter and status mux stay in `page_checker`.

## Test plan
- Reset, then release: `ready`=1, `pattern`=32'h00000001, `error`=0, `status`=8'h00.
- MODE 0, SEED A5, `page`=32'hA5A5A5A5, CHECK: `ready` low exactly 4 cycles. STAT 1 gives 8'h00; `error`=0.
- Same setup with `page`=32'hA5005AA5, CHECK: mask=4'b0110, so STAT 1 gives 8'h06. `error`=1, STAT 0 gives 8'h01.
- MODE 2, SEED 00, NEXT ×2: `pattern`=32'h80200003, then 32'hC0300002. MODE 3, SEED 1F, NEXT: 32'h80000000, then 32'h00000001.
- Pulse `inst_en` with CLEAR during a CMP cycle: ignored, and `ecnt` still increments at the end. 256 failing CHECKs saturate STAT 0 at 8'hFF. CLEAR then gives 8'h00 and `error`=0.
- Assert `reset` at the second CMP cycle of a failing CHECK: after release `ecnt`=0, `error`=0, `ready`=1.
